// File: rtl/otter_io_pkg.sv
// rtl/otter_io_pkg.sv - shared constants and types for the OTTER UART transmitter
// Contents: register offsets, STATUS bit indices, uart_state_t, default divisor,
// and the bit-period reload helper.
package otter_io_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_DIV    = 32'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 12;

  localparam logic [15:0] DEFAULT_DIVISOR = 16'd868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Bit counter reload value; a divisor of 0 behaves as 1 clock per bit.
  function automatic logic [15:0] reload_of(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO holding bytes waiting to be transmitted
// Ports: clk, rst (sync, active high); push/din write side; pop/dout read side
// (dout is the current head, valid while !empty); full, empty, count status.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Push while full is only issued together with a pop; the head is read
  // combinationally before the edge, so overwriting its slot is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/otter_uart_tx.sv
// rtl/otter_uart_tx.sv - memory-mapped 8N1 UART transmitter on the OTTER I/O bus
// Ports: CLK, RST (sync, active high); IOBUS_ADDR/IOBUS_OUT/IOBUS_WR CPU store
// side; RD_DATA combinational register read (0 outside the window); TX serial
// line (idle high); IRQ_EMPTY high while FIFO empty and transmitter idle.
// Registers: +0 TXDATA, +4 STATUS, +8 DIV.
// Option: define UART_TX_PARITY_EN for a parity bit (DIV bit 16 = odd parity).
module otter_uart_tx import otter_io_pkg::*; #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIVISOR    = DEFAULT_DIVISOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        IRQ_EMPTY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel_tx, sel_st, sel_div;
  logic          push_req, accept, pop;
  logic          full, empty, busy, bit_done;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic [15:0]   div_q, reload_q, cnt_q;
  logic [7:0]    data_q;
  logic [2:0]    idx_q;
  logic          ovf_q;
  uart_state_t   state, next_state;
  logic          unused_bits;

  assign sel_tx  = (IOBUS_ADDR == BASE_ADDR + OFF_TXDATA);
  assign sel_st  = (IOBUS_ADDR == BASE_ADDR + OFF_STATUS);
  assign sel_div = (IOBUS_ADDR == BASE_ADDR + OFF_DIV);

  assign bit_done = (cnt_q == 16'd0);
  // Load a new frame from idle, or straight out of the last stop clock so
  // back-to-back frames have no idle gap.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign push_req = IOBUS_WR && sel_tx;
  assign accept   = push_req && (!full || pop);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (accept),
    .din   (IOBUS_OUT[7:0]),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Overflow set has priority over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= DIVISOR;
      ovf_q <= 1'b0;
    end else begin
      if (IOBUS_WR && sel_div) div_q <= IOBUS_OUT[15:0];
      if (push_req && !accept) ovf_q <= 1'b1;
      else if (IOBUS_WR && sel_st && IOBUS_OUT[ST_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic odd_q, par_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      odd_q <= 1'b0;
      par_q <= 1'b0;
    end else begin
      if (IOBUS_WR && sel_div) odd_q <= IOBUS_OUT[16];
      if (pop) par_q <= (^head) ^ odd_q;
    end
  end
`endif

  // Frame datapath: the divisor is captured at load, so DIV writes during a
  // frame only take effect on the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q   <= 8'd0;
      reload_q <= 16'd0;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
    end else if (pop) begin
      data_q   <= head;
      reload_q <= reload_of(div_q);
      cnt_q    <= reload_of(div_q);
      idx_q    <= 3'd0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        cnt_q <= reload_q;
        if (state == DATA) idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (!empty) next_state = START;
      START:  if (bit_done) next_state = DATA;
      DATA:   if (bit_done && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                next_state = PARITY;
`else
                next_state = STOP;
`endif
              end
      PARITY: if (bit_done) next_state = STOP;
      STOP:   if (bit_done) next_state = empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    TX = 1'b1;
    case (state)
      START:  TX = 1'b0;
      DATA:   TX = data_q[idx_q];
`ifdef UART_TX_PARITY_EN
      PARITY: TX = par_q;
`endif
      default: TX = 1'b1;
    endcase
    busy      = (state != IDLE);
    IRQ_EMPTY = empty && !busy;
  end

  always_comb begin
    RD_DATA = 32'd0;
    if (sel_st) begin
      RD_DATA[ST_FULL]  = full;
      RD_DATA[ST_EMPTY] = empty;
      RD_DATA[ST_BUSY]  = busy;
      RD_DATA[ST_OVF]   = ovf_q;
      RD_DATA[ST_COUNT_MSB:ST_COUNT_LSB] = 9'(count);
    end else if (sel_div) begin
      RD_DATA[15:0] = div_q;
`ifdef UART_TX_PARITY_EN
      RD_DATA[16] = odd_q;
`endif
    end
  end

  assign unused_bits = ^IOBUS_OUT[31:16];

endmodule

// File: tb/tb_otter_uart_tx.sv
// tb/tb_otter_uart_tx.sv - directed self-checking bench for otter_uart_tx
module tb_otter_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] ST   = BASE + 32'h4;
  localparam logic [31:0] DIVA = BASE + 32'h8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT = 32'd0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] RD_DATA;
  logic        TX;
  logic        IRQ_EMPTY;

  int checks = 0;
  int failures = 0;

  otter_uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .TX         (TX),
    .IRQ_EMPTY  (IRQ_EMPTY)
  );

  always #5 CLK = ~CLK;

  // Expected line levels for one frame, index 0 = start bit.
  function automatic logic [63:0] frame(input logic [7:0] d, input logic odd);
    logic [63:0] f;
`ifdef UART_TX_PARITY_EN
    f = 64'({1'b1, (^d) ^ odd, d, 1'b0});
`else
    f = 64'({odd & 1'b0, 1'b1, d, 1'b0});
`endif
    return f;
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    IOBUS_ADDR = addr; IOBUS_OUT = data; IOBUS_WR = 1'b1;
    @(negedge CLK);
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0;
  endtask

  // Samples TX every clock; records the first sample of each bit and flags
  // any change within a bit period.
  task automatic capture(input int period, input int nbits, output logic [63:0] bits, output bit glitch);
    bits = 64'd0; glitch = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge CLK);
        if (c == 0) bits[b] = TX;
        else if (TX !== bits[b]) glitch = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (IRQ_EMPTY === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    IOBUS_ADDR = ST; #1;
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", TX); end
    checks++; if (IRQ_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_irq got=%b exp=1", IRQ_EMPTY); end
    checks++; if (RD_DATA !== 32'h2) begin failures++; $display("FAIL reset_status got=%h exp=%h", RD_DATA, 32'h2); end
    RST = 1'b0;
    @(negedge CLK);
    IOBUS_ADDR = DIVA; #1;
    checks++; if (RD_DATA !== 32'd868) begin failures++; $display("FAIL reset_div got=%0d exp=868", RD_DATA); end
    IOBUS_ADDR = BASE; #1;
    checks++; if (RD_DATA !== 32'd0) begin failures++; $display("FAIL txdata_read got=%h exp=0", RD_DATA); end
    IOBUS_ADDR = BASE + 32'hC; #1;
    checks++; if (RD_DATA !== 32'd0) begin failures++; $display("FAIL outside_read got=%h exp=0", RD_DATA); end
    IOBUS_ADDR = 32'd0;
  endtask

  task automatic test_frame;
    logic [63:0] bits, exp;
    bit gl;
    wr(DIVA, 32'd4);
    IOBUS_ADDR = DIVA; #1;
    checks++; if (RD_DATA !== 32'd4) begin failures++; $display("FAIL div_write got=%0d exp=4", RD_DATA); end
    wr(BASE + 32'hC, 32'h55);
    IOBUS_ADDR = ST; #1;
    checks++; if (RD_DATA !== 32'h2) begin failures++; $display("FAIL outside_write got=%h exp=%h", RD_DATA, 32'h2); end
    wr(BASE, 32'h55);
    IOBUS_ADDR = ST; #1;
    checks++; if (RD_DATA !== 32'h10) begin failures++; $display("FAIL count_after_push got=%h exp=%h", RD_DATA, 32'h10); end
    checks++; if (IRQ_EMPTY !== 1'b0) begin failures++; $display("FAIL irq_queued got=%b exp=0", IRQ_EMPTY); end
    IOBUS_ADDR = 32'd0;
    capture(4, NB, bits, gl);
    exp = frame(8'h55, 1'b0);
    checks++; if (bits !== exp) begin failures++; $display("FAIL frame_55 got=%h exp=%h", bits, exp); end
    checks++; if (gl !== 1'b0) begin failures++; $display("FAIL frame_55_timing got=%b exp=0", gl); end
    @(negedge CLK);
    checks++; if (IRQ_EMPTY !== 1'b1) begin failures++; $display("FAIL irq_after_stop got=%b exp=1", IRQ_EMPTY); end
  endtask

  task automatic test_div_zero;
    logic [63:0] bits, exp;
    bit gl;
    wr(DIVA, 32'd0);
    wr(BASE, 32'hA5);
    capture(1, NB, bits, gl);
    exp = frame(8'hA5, 1'b0);
    checks++; if (bits !== exp) begin failures++; $display("FAIL div0_frame got=%h exp=%h", bits, exp); end
    @(negedge CLK);
    checks++; if (IRQ_EMPTY !== 1'b1) begin failures++; $display("FAIL div0_idle got=%b exp=1", IRQ_EMPTY); end
    wr(DIVA, 32'd4);
  endtask

  task automatic test_back_to_back;
    logic [63:0] bits, exp;
    bit gl;
    @(negedge CLK); IOBUS_ADDR = BASE; IOBUS_OUT = 32'h12; IOBUS_WR = 1'b1;
    @(negedge CLK); IOBUS_OUT = 32'hC3;
    fork
      begin
        @(negedge CLK); IOBUS_OUT = 32'h80;
        @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = ST; #1;
        checks++; if (RD_DATA !== 32'h24) begin failures++; $display("FAIL status_busy_count got=%h exp=%h", RD_DATA, 32'h24); end
        IOBUS_ADDR = 32'd0;
      end
      capture(4, 3 * NB, bits, gl);
    join
    exp = frame(8'h12, 1'b0) | (frame(8'hC3, 1'b0) << NB) | (frame(8'h80, 1'b0) << (2 * NB));
    checks++; if (bits !== exp) begin failures++; $display("FAIL back_to_back got=%h exp=%h", bits, exp); end
    checks++; if (gl !== 1'b0) begin failures++; $display("FAIL back_to_back_timing got=%b exp=0", gl); end
    @(negedge CLK);
    checks++; if (IRQ_EMPTY !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", IRQ_EMPTY); end
  endtask

  task automatic test_div_midframe;
    logic [63:0] b1, b2, e1, e2;
    bit g1, g2;
    @(negedge CLK); IOBUS_ADDR = BASE; IOBUS_OUT = 32'hA3; IOBUS_WR = 1'b1;
    @(negedge CLK); IOBUS_OUT = 32'h3C;
    fork
      begin
        @(negedge CLK); IOBUS_ADDR = DIVA; IOBUS_OUT = 32'd8;
        @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0;
      end
      begin
        capture(4, NB, b1, g1);
        capture(8, NB, b2, g2);
      end
    join
    e1 = frame(8'hA3, 1'b0);
    e2 = frame(8'h3C, 1'b0);
    checks++; if (b1 !== e1 || g1 !== 1'b0) begin failures++; $display("FAIL div_mid_old got=%h/%b exp=%h/0", b1, g1, e1); end
    checks++; if (b2 !== e2 || g2 !== 1'b0) begin failures++; $display("FAIL div_mid_new got=%h/%b exp=%h/0", b2, g2, e2); end
    wr(DIVA, 32'd4);
  endtask

  task automatic test_overflow;
    bit ok;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK); IOBUS_ADDR = BASE; IOBUS_OUT = 32'(i); IOBUS_WR = 1'b1;
    end
    @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = ST; #1;
    checks++; if (RD_DATA !== 32'h10D) begin failures++; $display("FAIL overflow_status got=%h exp=%h", RD_DATA, 32'h10D); end
    wr(ST, 32'h8);
    IOBUS_ADDR = ST; #1;
    checks++; if (RD_DATA !== 32'h105) begin failures++; $display("FAIL overflow_clear got=%h exp=%h", RD_DATA, 32'h105); end
    IOBUS_ADDR = 32'd0;
    wait_idle(2000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", ok); end
    IOBUS_ADDR = ST; #1;
    checks++; if (RD_DATA !== 32'h2) begin failures++; $display("FAIL drained_status got=%h exp=%h", RD_DATA, 32'h2); end
    IOBUS_ADDR = 32'd0;
  endtask

  task automatic test_reset_midframe;
    bit stuck;
    @(negedge CLK); IOBUS_ADDR = BASE; IOBUS_OUT = 32'h00; IOBUS_WR = 1'b1;
    @(negedge CLK); IOBUS_OUT = 32'h00;
    @(negedge CLK); IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0;
    repeat (16) @(negedge CLK);
    IOBUS_ADDR = ST; #1;
    checks++; if (TX !== 1'b0) begin failures++; $display("FAIL data_bit3_low got=%b exp=0", TX); end
    checks++; if (RD_DATA !== 32'h14) begin failures++; $display("FAIL pre_reset_status got=%h exp=%h", RD_DATA, 32'h14); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (TX !== 1'b1) begin failures++; $display("FAIL reset_mid_tx got=%b exp=1", TX); end
    RST = 1'b0;
    #1;
    checks++; if (RD_DATA !== 32'h2) begin failures++; $display("FAIL reset_mid_status got=%h exp=%h", RD_DATA, 32'h2); end
    IOBUS_ADDR = DIVA; #1;
    checks++; if (RD_DATA !== 32'd868) begin failures++; $display("FAIL reset_mid_div got=%0d exp=868", RD_DATA); end
    IOBUS_ADDR = 32'd0;
    stuck = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (TX !== 1'b1 || IRQ_EMPTY !== 1'b1) stuck = 1'b1;
    end
    checks++; if (stuck !== 1'b0) begin failures++; $display("FAIL reset_mid_aborted got=%b exp=0", stuck); end
    wr(DIVA, 32'd4);
  endtask

  task automatic test_div_bit16;
`ifdef UART_TX_PARITY_EN
    logic [63:0] bits, exp;
    bit gl;
    wr(DIVA, 32'd4);
    wr(BASE, 32'h07);
    capture(4, NB, bits, gl);
    exp = 64'({1'b1, 1'b1, 8'h07, 1'b0});
    checks++; if (bits !== exp || gl !== 1'b0) begin failures++; $display("FAIL parity_even got=%h/%b exp=%h/0", bits, gl, exp); end
    wr(DIVA, 32'h1_0004);
    IOBUS_ADDR = DIVA; #1;
    checks++; if (RD_DATA !== 32'h1_0004) begin failures++; $display("FAIL div_odd_read got=%h exp=%h", RD_DATA, 32'h1_0004); end
    IOBUS_ADDR = 32'd0;
    wr(BASE, 32'h07);
    capture(4, NB, bits, gl);
    exp = 64'({1'b1, 1'b0, 8'h07, 1'b0});
    checks++; if (bits !== exp || gl !== 1'b0) begin failures++; $display("FAIL parity_odd got=%h/%b exp=%h/0", bits, gl, exp); end
`else
    wr(DIVA, 32'h1_0004);
    IOBUS_ADDR = DIVA; #1;
    checks++; if (RD_DATA !== 32'h4) begin failures++; $display("FAIL div_bit16_ignored got=%h exp=%h", RD_DATA, 32'h4); end
    IOBUS_ADDR = 32'd0;
`endif
  endtask

  initial begin
    test_reset;
    test_frame;
    test_div_zero;
    test_back_to_back;
    test_div_midframe;
    test_overflow;
    test_reset_midframe;
    test_div_bit16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
